burst_count_ctrl: RTL and testbench
===================================

Name: burst_count_ctrl

Overview:
- Control FSM that drives the team's 4-bit loadable down counter.
- Outputs to the counter: clk_en, ld_cnt, cnt_en and num_data. Input from the counter: its terminal flag co_d, which is high when count == 1.
- Accepts a start request with a 4-bit burst length N and generates a prescaled tick stream: exactly N tick_out pulses, then a one-cycle done pulse.
- Sits between the lab top-level/user inputs and the counter instance.

Parameters:
- PRESCALE, 4, number of clock cycles per clk_en pulse; legal range 1..256.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; sampled on clock only in IDLE.
- num_in  input  4  burst length N, captured when start is accepted.
- co_d  input  1  counter terminal flag (counter value == 1).
- clk_en  output  1  counter clock enable; one-cycle pulse every PRESCALE cycles while active.
- ld_cnt  output  1  counter load strobe (counter loads num_data when ld_cnt & clk_en).
- cnt_en  output  1  counter decrement enable.
- num_data  output  4  captured N, driven to the counter load input.
- busy  output  1  high whenever state != IDLE.
- tick_out  output  1  one-cycle pulse per counted tick.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async): state=IDLE, prescaler=0, num_data=0. All outputs 0.
- Clock domain: single clock. No combinational path from inputs to outputs, except cnt_en, which depends on co_d.
- Prescaler: 8-bit, cleared on every state entry and held at 0 in IDLE/DONE.
  - Counts 0..PRESCALE-1, then wraps.
  - clk_en = (state is LOAD or COUNT) && prescaler == PRESCALE-1.
  - PRESCALE=1 gives clk_en constantly high in LOAD/COUNT.
- IDLE: on start=1:
  - num_in != 0: num_data <= num_in, go to LOAD.
  - num_in == 0: go directly to DONE; no ticks, num_data unchanged.
- LOAD: ld_cnt=1; co_d ignored. When clk_en=1, go to COUNT at the same edge the counter loads.
- COUNT:
  - cnt_en = !co_d. tick_out = clk_en.
  - On clk_en with co_d=1, go to DONE. The counter holds at 1, because cnt_en=0 in that cycle.
  - Result: N ticks for counter values N..1.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy: ignored (unless RETRIGGER_EN).
- start held high continuously: a new burst is accepted in the first IDLE cycle after DONE.
- Latency: start accepted at edge e0.
  - LOAD lasts PRESCALE cycles.
  - Tick k (1..N) occurs at the clock edge e0 + PRESCALE*(k+1).
  - done is high in the cycle following edge e0 + PRESCALE*(N+1).
  - busy is high for PRESCALE*(N+1)+1 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse.

Optional Feature:
- Macro: RETRIGGER_EN.
- Defined: start=1 in LOAD or COUNT with num_in != 0 captures num_in into num_data, re-enters LOAD and clears the prescaler. Ticks already issued are not counted toward the new burst, and no done pulse is issued for the aborted burst. start with num_in == 0 is still ignored while busy.
- Undefined: start is ignored in every state except IDLE.

Test Plan:
- PRESCALE=4, num_in=3, one-cycle start, counter instance attached -> ticks at edges e0+8, e0+12, e0+16; done high in cycle after e0+16; busy high 17 cycles; counter ends at 1.
- num_in=1 -> ld then single tick at e0+8 with co_d already 1; done after e0+8; cnt_en=0 during that tick.
- num_in=0 with start -> state DONE next cycle, zero ticks, done pulse one cycle after start edge, clk_en never asserted.
- num_in=15, start re-pulsed during COUNT (macro undefined) -> still exactly 15 ticks, single done.
- Reset asserted mid-COUNT (after 2 ticks of N=5) -> busy, tick_out, clk_en, done drop to 0 asynchronously. A fresh start with N=2 then gives exactly 2 ticks.
- RETRIGGER_EN defined, N=5, restart with num_in=2 after 3 ticks -> 2 further ticks, one done, num_data=2.

Source files
------------

// File: rtl/burst_count_ctrl.sv
// burst_count_ctrl: control FSM for the 4-bit loadable down counter.
// A start request with burst length N produces a prescaled clock-enable
// stream, a load phase, N tick_out pulses and a single done pulse.
// The load phase and each counted tick last PRESCALE clock cycles.
// Optional build macro RETRIGGER_EN: while loading or counting, a start
// with non-zero num_in recaptures num_in and restarts the load phase.
module burst_count_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] num_in,
  input  logic       co_d,
  output logic       clk_en,
  output logic       ld_cnt,
  output logic       cnt_en,
  output logic [3:0] num_data,
  output logic       busy,
  output logic       tick_out,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LP_PRESC_TOP = 8'(PRESCALE - 1);

  state_t     r_state;
  logic [7:0] r_presc;
  logic [3:0] r_num;

  logic w_active;
  logic w_wrap;
  logic w_retrig;

  assign w_active = (r_state == S_LOAD) || (r_state == S_COUNT);
  assign w_wrap   = (r_presc == LP_PRESC_TOP);

`ifdef RETRIGGER_EN
  assign w_retrig = w_active && start && (num_in != 4'd0);
`else
  assign w_retrig = 1'b0;
`endif

  // State, prescaler and captured burst length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_num   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (start) begin
            if (num_in != 4'd0) begin
              r_num   <= num_in;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (w_retrig) begin
            r_num   <= num_in;
            r_presc <= '0;
          end else if (w_wrap) begin
            // Counter loads num_data on this same edge.
            r_presc <= '0;
            r_state <= S_COUNT;
          end else begin
            r_presc <= r_presc + 8'd1;
          end
        end
        S_COUNT: begin
          if (w_retrig) begin
            r_num   <= num_in;
            r_presc <= '0;
            r_state <= S_LOAD;
          end else if (w_wrap) begin
            // The last tick is the one issued while the counter sits at 1.
            r_presc <= '0;
            if (co_d) begin
              r_state <= S_DONE;
            end
          end else begin
            r_presc <= r_presc + 8'd1;
          end
        end
        S_DONE: begin
          r_presc <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_presc <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; only cnt_en looks at co_d.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    ld_cnt   = (r_state == S_LOAD);
    clk_en   = w_active && w_wrap;
    tick_out = (r_state == S_COUNT) && w_wrap;
    cnt_en   = (r_state == S_COUNT) && !co_d;
    num_data = r_num;
  end

endmodule

// File: tb/tb_burst_count_ctrl.sv
// tb_burst_count_ctrl: drives burst_count_ctrl with an attached 4-bit
// loadable down counter, checks every cycle against a timeline model
// (burst phase computed from cycles elapsed since start acceptance),
// and pins the model with hand-computed burst measurements.
module tb_burst_count_ctrl;

  localparam int P = 4;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] num_in;
  logic       co_d;
  logic       clk_en;
  logic       ld_cnt;
  logic       cnt_en;
  logic [3:0] num_data;
  logic       busy;
  logic       tick_out;
  logic       done;

  burst_count_ctrl #(.PRESCALE(P)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .num_in   (num_in),
    .co_d     (co_d),
    .clk_en   (clk_en),
    .ld_cnt   (ld_cnt),
    .cnt_en   (cnt_en),
    .num_data (num_data),
    .busy     (busy),
    .tick_out (tick_out),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Attached down counter: loads on ld_cnt&clk_en, decrements on cnt_en&clk_en.
  logic [3:0] r_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) r_cnt <= 4'd0;
    else if (clk_en) begin
      if (ld_cnt) r_cnt <= num_data;
      else if (cnt_en) r_cnt <= r_cnt - 4'd1;
    end
  end
  assign co_d = (r_cnt == 4'd1);

  int n_vec;
  int n_err;

  // Timeline model: m_j = cycles since the accepting edge of the current burst.
  bit         m_act;
  int         m_j;
  int         m_n;
  logic [3:0] m_numd;

  function automatic int end_j();
    return (m_n == 0) ? 0 : P * (m_n + 1);
  endfunction

  task automatic model_step();
    bit rt;
    rt = 1'b0;
    if (reset) begin
      m_act = 1'b0; m_j = 0; m_n = 0; m_numd = 4'd0;
    end else if (m_act) begin
`ifdef RETRIGGER_EN
      rt = (m_n > 0) && (m_j < end_j()) && start && (num_in != 4'd0);
`endif
      if (rt) begin
        m_j = 0; m_n = int'(num_in); m_numd = num_in;
      end else if (m_j == end_j()) begin
        m_act = 1'b0;
      end else begin
        m_j++;
      end
    end else if (start) begin
      m_act = 1'b1; m_j = 0; m_n = int'(num_in);
      if (num_in != 4'd0) m_numd = num_in;
    end
  endtask

  task automatic compare();
    int e;
    logic [9:0] exp_v;
    logic [9:0] act_v;
    logic eb, ed, el, ec, et, en;
    e  = end_j();
    eb = m_act;
    ed = m_act && (m_j == e);
    el = m_act && (m_n > 0) && (m_j < P);
    ec = m_act && (m_n > 0) && (m_j < e) && (((m_j + 1) % P) == 0);
    et = ec && (m_j >= P);
    en = m_act && (m_n > 0) && (m_j >= P) && (m_j < e) && ((m_n - (m_j - P) / P) != 1);
    exp_v = {eb, ed, el, ec, et, en, m_numd};
    act_v = {busy, done, ld_cnt, clk_en, tick_out, cnt_en, num_data};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t busy/done/ld/clken/tick/cnten/num got %b expected %b",
               $time, act_v, exp_v);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One burst from idle; optional second start pulse after sample index pj.
  task automatic burst(input logic [3:0] n, input int win, input int pj,
                       input logic [3:0] pn, output int ticks, output int dones,
                       output int busyc, output int ftick, output int ltick,
                       output int dj, output int clks, output int tce);
    ticks = 0; dones = 0; busyc = 0; ftick = -1; ltick = -1;
    dj = -1; clks = 0; tce = 0;
    start = 1'b1; num_in = n;
    for (int j = 0; j < win; j++) begin
      cycle();
      if (tick_out) begin ticks++; if (ftick < 0) ftick = j; ltick = j; end
      if (done) begin dones++; dj = j; end
      if (busy) busyc++;
      if (clk_en) clks++;
      if (tick_out && cnt_en) tce++;
      start  = (j == pj);
      num_in = (j == pj) ? pn : n;
    end
    start = 1'b0;
  endtask

  int tk, dn, bc, ft, lt, dj, ck, tc;
  int rst_left;

  initial begin
    n_vec = 0; n_err = 0;
    m_act = 1'b0; m_j = 0; m_n = 0; m_numd = 4'd0;
    reset = 1'b1; start = 1'b0; num_in = 4'd0;
    cycle(); cycle();
    chk("reset_outputs", int'({busy, done, ld_cnt, clk_en, tick_out, cnt_en, num_data}), 0);
    reset = 1'b0;
    cycle(); cycle();

    // N=3: ticks at e0+8/12/16, done after e0+16, busy 17 cycles.
    burst(4'd3, 24, -1, 4'd0, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("n3_ticks", tk, 3);
    chk("n3_first_tick", ft, 7);
    chk("n3_last_tick", lt, 15);
    chk("n3_done_at", dj, 16);
    chk("n3_busy_cycles", bc, 17);
    chk("n3_clk_en_pulses", ck, 4);
    chk("n3_tick_with_cnt_en", tc, 2);
    chk("n3_counter_final", int'(r_cnt), 1);
    chk("n3_num_data", int'(num_data), 3);

    // N=1: single tick with the counter already at 1.
    burst(4'd1, 16, -1, 4'd0, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("n1_ticks", tk, 1);
    chk("n1_tick_at", ft, 7);
    chk("n1_done_at", dj, 8);
    chk("n1_tick_with_cnt_en", tc, 0);

    // N=0: straight to done, no clk_en at all.
    burst(4'd0, 6, -1, 4'd0, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("n0_ticks", tk, 0);
    chk("n0_clk_en_pulses", ck, 0);
    chk("n0_done_at", dj, 0);
    chk("n0_busy_cycles", bc, 1);
    chk("n0_num_data_kept", int'(num_data), 1);

`ifndef RETRIGGER_EN
    // N=15 with a stray start during COUNT: ignored.
    burst(4'd15, 72, 30, 4'd7, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("n15_ticks", tk, 15);
    chk("n15_dones", dn, 1);
    chk("n15_busy_cycles", bc, 65);
    chk("n15_done_at", dj, 64);
    chk("n15_num_data", int'(num_data), 15);
`else
    // N=5 restarted with 2 after the third tick.
    burst(4'd5, 40, 16, 4'd2, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("rt_ticks_total", tk, 5);
    chk("rt_dones", dn, 1);
    chk("rt_done_at", dj, 29);
    chk("rt_num_data", int'(num_data), 2);
`endif

    // Reset in the middle of COUNT after two ticks of N=5.
    tk = 0;
    start = 1'b1; num_in = 4'd5;
    for (int j = 0; j < 14; j++) begin
      cycle();
      if (tick_out) tk++;
      start = 1'b0;
    end
    chk("mid_reset_ticks_before", tk, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_async_outputs", int'({busy, done, ld_cnt, clk_en, tick_out, cnt_en, num_data}), 0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    burst(4'd2, 20, -1, 4'd0, tk, dn, bc, ft, lt, dj, ck, tc);
    chk("after_reset_n2_ticks", tk, 2);
    chk("after_reset_n2_dones", dn, 1);

    // Randomized traffic, including held starts and occasional resets.
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (rst_left > 0) begin
        rst_left--;
        reset = (rst_left > 0);
      end else if ($urandom_range(0, 199) == 0) begin
        rst_left = int'($urandom_range(1, 3)) + 1;
        reset = 1'b1;
      end
      start  = ($urandom_range(0, 5) == 0);
      num_in = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    end
    reset = 1'b0; start = 1'b0;
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
